// File: rtl/seg7_scan_decoder_pkg.sv
// Shared seven-segment constants for the display driver and the scan readback decoder.
// Segment patterns are active-low, with bit 6 = a and bit 0 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_t;

  // Exactly one bit set; narrower selects are zero-extended by the caller.
  function automatic logic onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder, inverse of the driver's encode table.
// All-off reads as a blank digit; anything outside the table is flagged as an error.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       is_blank,
  output logic       is_err
);

  // Table lookup of the active-low pattern
  always_comb begin
    code     = CODE_ERR;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: begin
        code     = CODE_BLANK;
        is_blank = 1'b1;
      end
      default: begin
        code   = CODE_ERR;
        is_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scanned seven-segment display readback: waits for each digit's pattern to settle,
// decodes it back to BCD and delivers complete frames on a valid/ready port.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  overrun
);

  localparam int                CW         = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]     CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]     CNT_FULL   = CW'(STABLE_CYC);
  localparam logic [CW-1:0]     CNT_LAST   = CW'(STABLE_CYC - 1);
  localparam logic [DIGITS-1:0] ALL_DIGITS = {DIGITS{1'b1}};
  localparam logic [DIGITS-1:0] NO_DIGITS  = {DIGITS{1'b0}};

  logic [6:0]          s_seg_q, p_seg_q;
  logic [DIGITS-1:0]   s_sel_q, p_sel_q;
  scan_state_t         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [4*DIGITS-1:0] stage_code_q, stage_code_d;
  logic [DIGITS-1:0]   stage_blank_q, stage_blank_d;
  logic [DIGITS-1:0]   stage_err_q, stage_err_d;
  logic [DIGITS-1:0]   mask_q, mask_d;

  logic                valid_q, valid_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                overrun_q, overrun_d;

  logic [7:0]          sel_ext_s;
  logic                sel_onehot_s;
  logic                same_s;
  logic                capture_s;
  logic                frame_done_s;
  logic [3:0]          dec_code_s;
  logic                dec_blank_s;
  logic                dec_err_s;

  seg7_pattern_decode u_decode (
    .pattern  (s_seg_q),
    .code     (dec_code_s),
    .is_blank (dec_blank_s),
    .is_err   (dec_err_s)
  );

  // Select qualification and sample-to-sample stability compare
  always_comb begin
    sel_ext_s               = 8'd0;
    sel_ext_s[DIGITS-1:0]   = s_sel_q;
    sel_onehot_s            = onehot8(sel_ext_s);
    same_s                  = (s_seg_q == p_seg_q) && (s_sel_q == p_sel_q);
  end

  // Input sample stage plus one cycle of history for the stability compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_seg_q <= 7'd0;
      s_sel_q <= NO_DIGITS;
      p_seg_q <= 7'd0;
      p_sel_q <= NO_DIGITS;
    end else begin
      s_seg_q <= seg_in;
      s_sel_q <= dig_sel;
      p_seg_q <= s_seg_q;
      p_sel_q <= s_sel_q;
    end
  end

  // Stability FSM: one capture per settled dwell, restarted by any change
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_onehot_s) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      SETTLE: begin
        if (!sel_onehot_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (!same_s) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = HELD;
          cnt_d     = CNT_FULL;
          capture_s = 1'b1;
        end else begin
          state_d = SETTLE;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sel_onehot_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (!same_s) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = HELD;
          cnt_d   = CNT_FULL;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Staging update on capture; frame hand-off or overrun when every slot is filled
  always_comb begin
    stage_code_d  = stage_code_q;
    stage_blank_d = stage_blank_q;
    stage_err_d   = stage_err_q;
    mask_d        = mask_q;
    valid_d       = valid_q;
    digits_d      = digits_q;
    blank_d       = blank_q;
    err_d         = err_q;
    overrun_d     = 1'b0;
    frame_done_s  = 1'b0;
    if (capture_s) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (s_sel_q[i]) begin
          stage_code_d[4*i +: 4] = dec_code_s;
          stage_blank_d[i]       = dec_blank_s;
          stage_err_d[i]         = dec_err_s;
        end else begin
          stage_code_d[4*i +: 4] = stage_code_q[4*i +: 4];
        end
      end
      mask_d       = mask_q | s_sel_q;
      frame_done_s = (mask_d == ALL_DIGITS);
    end else begin
      mask_d = mask_q;
    end

    if (frame_done_s) begin
      mask_d = NO_DIGITS;
      if (!valid_q || out_ready) begin
        digits_d = stage_code_d;
        blank_d  = stage_blank_d;
        err_d    = stage_err_d;
        valid_d  = 1'b1;
      end else begin
        // Consumer still holds the previous frame: drop this one, keep outputs
        stage_code_d  = {(4*DIGITS){1'b0}};
        stage_blank_d = NO_DIGITS;
        stage_err_d   = NO_DIGITS;
        overrun_d     = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_code_q  <= {(4*DIGITS){1'b0}};
      stage_blank_q <= NO_DIGITS;
      stage_err_q   <= NO_DIGITS;
      mask_q        <= NO_DIGITS;
      valid_q       <= 1'b0;
      digits_q      <= {(4*DIGITS){1'b0}};
      blank_q       <= NO_DIGITS;
      err_q         <= NO_DIGITS;
      overrun_q     <= 1'b0;
    end else begin
      stage_code_q  <= stage_code_d;
      stage_blank_q <= stage_blank_d;
      stage_err_q   <= stage_err_d;
      mask_q        <= mask_d;
      valid_q       <= valid_d;
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign digits    = digits_q;
  assign blank     = blank_q;
  assign digit_err = err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus a randomized scan checked cycle by
// cycle against a run-length reference model of the sampled display bus.
module tb_seg7_scan_decoder;

  localparam int DIGITS     = 4;
  localparam int STABLE_CYC = 4;

  logic                clk;
  logic                rst;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic                out_ready;
  logic                out_valid;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   digit_err;
  logic                overrun;

  int vectors;
  int miscompares;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .digits    (digits),
    .blank     (blank),
    .digit_err (digit_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]          m_seg;
  logic [DIGITS-1:0]   m_sel;
  int                  m_run;
  logic [3:0]          m_code [DIGITS];
  logic [DIGITS-1:0]   m_sblank, m_serr, m_mask;
  logic                m_valid, m_ovr;
  logic [4*DIGITS-1:0] m_digits;
  logic [DIGITS-1:0]   m_blank, m_err;

  // monitor state used by the directed scenarios
  int                  rises, ovr_cnt, track_err;
  logic                prev_valid;
  logic [4*DIGITS-1:0] snap_digits;
  logic [DIGITS-1:0]   snap_blank, snap_err;

  function automatic logic [6:0] pat_of(input int d);
    logic [6:0] t [10];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
          7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return t[d];
  endfunction

  task automatic ref_decode(input logic [6:0] p, output logic [3:0] c, output logic b, output logic e);
    c = 4'hE; b = 1'b0; e = 1'b1;
    if (p == 7'h7F) begin c = 4'hF; b = 1'b1; e = 1'b0; end
    for (int d = 0; d < 10; d++)
      if (pat_of(d) == p) begin c = 4'(d); b = 1'b0; e = 1'b0; end
  endtask

  task automatic model_reset();
    m_seg = 7'd0; m_sel = '0; m_run = 1;
    for (int i = 0; i < DIGITS; i++) m_code[i] = 4'd0;
    m_sblank = '0; m_serr = '0; m_mask = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_digits = '0; m_blank = '0; m_err = '0;
  endtask

  // A sample is captured once, at the edge after it has been seen on exactly
  // STABLE_CYC consecutive edges with a single digit enabled.
  task automatic model_edge();
    logic cap; int idx; logic [3:0] c; logic b, e;
    cap   = ($countones(m_sel) == 1) && (m_run == STABLE_CYC);
    m_ovr = 1'b0;
    idx   = 0;
    for (int i = 0; i < DIGITS; i++) if (m_sel[i]) idx = i;
    if (cap) begin
      ref_decode(m_seg, c, b, e);
      m_code[idx] = c; m_sblank[idx] = b; m_serr[idx] = e; m_mask[idx] = 1'b1;
    end
    if (cap && m_mask == '1) begin
      m_mask = '0;
      if (!m_valid || out_ready) begin
        for (int i = 0; i < DIGITS; i++) m_digits[4*i +: 4] = m_code[i];
        m_blank = m_sblank; m_err = m_serr; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (seg_in == m_seg && dig_sel == m_sel) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_seg = seg_in; m_sel = dig_sel;
  endtask

  task automatic clear_mon();
    rises = 0; ovr_cnt = 0; track_err = 0;
    snap_digits = '0; snap_blank = '0; snap_err = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset(); else model_edge();
    #1;
    if (out_valid !== m_valid || digits !== m_digits || blank !== m_blank ||
        digit_err !== m_err || overrun !== m_ovr) track_err++;
    if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
      rises++; snap_digits = digits; snap_blank = blank; snap_err = digit_err;
    end
    if (overrun === 1'b1) ovr_cnt++;
    prev_valid = out_valid;
  endtask

  task automatic drive(input int idx, input logic [6:0] pat, input int n);
    seg_in  = pat;
    dig_sel = (idx < 0) ? '0 : (DIGITS'(1) << idx);
    repeat (n) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; seg_in = 7'h7F; dig_sel = '0; out_ready = 1'b0;
    prev_valid = 1'b0; model_reset(); clear_mon();
    repeat (3) step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (digits !== 16'h0000) begin miscompares++; $display("FAIL reset_digits got %h want 0000", digits); end
    vectors++; if (blank !== 4'b0000) begin miscompares++; $display("FAIL reset_blank got %b want 0000", blank); end
    vectors++; if (digit_err !== 4'b0000) begin miscompares++; $display("FAIL reset_err got %b want 0000", digit_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    #3 rst = 1'b1;
  endtask

  task automatic test_steady_scan();
    clear_mon(); out_ready = 1'b1;
    for (int d = 0; d < 4; d++) drive(d, pat_of(d + 1), 8);
    drive(-1, 7'h7F, 3);
    vectors++; if (rises !== 1) begin miscompares++; $display("FAIL scan_frames got %0d want 1", rises); end
    vectors++; if (snap_digits !== 16'h4321) begin miscompares++; $display("FAIL scan_digits got %h want 4321", snap_digits); end
    vectors++; if (snap_blank !== 4'b0000 || snap_err !== 4'b0000) begin miscompares++; $display("FAIL scan_flags got %b/%b want 0000/0000", snap_blank, snap_err); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL scan_valid_drop got %b want 0", out_valid); end
    vectors++; if (track_err !== 0) begin miscompares++; $display("FAIL scan_model got %0d bad cycles want 0", track_err); end
  endtask

  task automatic test_glitch();
    clear_mon(); out_ready = 1'b1;
    drive(0, 7'b0010010, 3);
    drive(0, 7'b0000110, 8);
    for (int d = 1; d < 4; d++) drive(d, pat_of(d + 4), 8);
    drive(-1, 7'h7F, 3);
    vectors++; if (rises !== 1) begin miscompares++; $display("FAIL glitch_frames got %0d want 1", rises); end
    vectors++; if (snap_digits !== 16'h7653) begin miscompares++; $display("FAIL glitch_digits got %h want 7653", snap_digits); end
    vectors++; if (track_err !== 0) begin miscompares++; $display("FAIL glitch_model got %0d bad cycles want 0", track_err); end
  endtask

  task automatic test_bad_blank();
    clear_mon(); out_ready = 1'b1;
    drive(0, pat_of(9), 8);
    drive(1, 7'b1111110, 8);
    drive(2, 7'b1111111, 8);
    drive(3, pat_of(9), 8);
    drive(-1, 7'h7F, 3);
    vectors++; if (snap_digits !== 16'h9FE9) begin miscompares++; $display("FAIL bad_digits got %h want 9fe9", snap_digits); end
    vectors++; if (snap_err !== 4'b0010) begin miscompares++; $display("FAIL bad_err got %b want 0010", snap_err); end
    vectors++; if (snap_blank !== 4'b0100) begin miscompares++; $display("FAIL bad_blank got %b want 0100", snap_blank); end
    vectors++; if (track_err !== 0) begin miscompares++; $display("FAIL bad_model got %0d bad cycles want 0", track_err); end
  endtask

  task automatic test_back_to_back();
    clear_mon(); out_ready = 1'b0;
    for (int d = 0; d < 4; d++) drive(d, pat_of(d + 5), 8);
    for (int d = 0; d < 4; d++) drive(d, pat_of(d), 8);
    drive(-1, 7'h7F, 2);
    vectors++; if (rises !== 1) begin miscompares++; $display("FAIL bp_frames got %0d want 1", rises); end
    vectors++; if (digits !== 16'h8765) begin miscompares++; $display("FAIL bp_held got %h want 8765", digits); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %b want 1", out_valid); end
    vectors++; if (ovr_cnt !== 1) begin miscompares++; $display("FAIL bp_overrun got %0d pulses want 1", ovr_cnt); end
    vectors++; if (track_err !== 0) begin miscompares++; $display("FAIL bp_model got %0d bad cycles want 0", track_err); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_accept got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    clear_mon(); out_ready = 1'b1;
    drive(0, pat_of(9), 8);
    drive(1, pat_of(9), 8);
    drive(2, pat_of(1), 2);
    #3 rst = 1'b0; model_reset();
    #1;
    vectors++; if (digits !== 16'h0000 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_async got %h/%b want 0000/0", digits, out_valid); end
    repeat (3) step();
    #3 rst = 1'b1;
    clear_mon();
    drive(2, pat_of(1), 8);
    drive(3, pat_of(2), 8);
    vectors++; if (rises !== 0) begin miscompares++; $display("FAIL rstmid_partial got %0d frames want 0", rises); end
    drive(0, pat_of(5), 8);
    drive(1, pat_of(6), 8);
    drive(-1, 7'h7F, 2);
    vectors++; if (rises !== 1) begin miscompares++; $display("FAIL rstmid_frames got %0d want 1", rises); end
    vectors++; if (snap_digits !== 16'h2165) begin miscompares++; $display("FAIL rstmid_digits got %h want 2165", snap_digits); end
    vectors++; if (track_err !== 0) begin miscompares++; $display("FAIL rstmid_model got %0d bad cycles want 0", track_err); end
  endtask

  task automatic test_illegal_sel();
    clear_mon(); out_ready = 1'b1;
    seg_in = pat_of(3); dig_sel = 4'b0110;
    repeat (10) step();
    drive(-1, 7'h7F, 2);
    vectors++; if (rises !== 0) begin miscompares++; $display("FAIL illegal_frames got %0d want 0", rises); end
    for (int d = 0; d < 4; d++) drive(d, pat_of(9 - d), 8);
    drive(-1, 7'h7F, 2);
    vectors++; if (snap_digits !== 16'h6789) begin miscompares++; $display("FAIL illegal_next got %h want 6789", snap_digits); end
    vectors++; if (track_err !== 0) begin miscompares++; $display("FAIL illegal_model got %0d bad cycles want 0", track_err); end
  endtask

  task automatic test_random();
    int r, dwell;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) dig_sel = DIGITS'($urandom);
      else        dig_sel = DIGITS'(1) << $urandom_range(0, DIGITS - 1);
      r = $urandom_range(0, 9);
      if (r == 0)      seg_in = 7'h7F;
      else if (r == 1) seg_in = 7'($urandom);
      else             seg_in = pat_of($urandom_range(0, 9));
      dwell = $urandom_range(1, 10);
      for (int c = 0; c < dwell; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
        vectors++; if (out_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid got %b want %b", out_valid, m_valid); end
        vectors++; if (digits !== m_digits) begin miscompares++; $display("FAIL rnd_digits got %h want %h", digits, m_digits); end
        vectors++; if (blank !== m_blank) begin miscompares++; $display("FAIL rnd_blank got %b want %b", blank, m_blank); end
        vectors++; if (digit_err !== m_err) begin miscompares++; $display("FAIL rnd_err got %b want %b", digit_err, m_err); end
        vectors++; if (overrun !== m_ovr) begin miscompares++; $display("FAIL rnd_overrun got %b want %b", overrun, m_ovr); end
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    test_reset();
    test_steady_scan();
    test_glitch();
    test_bad_blank();
    test_back_to_back();
    test_reset_mid();
    test_illegal_sel();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
